// File: rtl/rob_retire_pkg.sv
// Shared types and constants for the reorder buffer / retire stage.
// Entry rows, retire bundles and entry-type helpers.
package rob_retire_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int PREG_W_DEF    = 6;
  localparam int DATA_W_DEF    = 32;

  localparam logic [1:0] ROB_T_REG   = 2'd0;
  localparam logic [1:0] ROB_T_STORE = 2'd1;
  localparam logic [1:0] ROB_T_LOAD  = 2'd2;

  typedef struct packed {
    logic                  v;
    logic                  comp;
    logic [1:0]            typ;
    logic [PREG_W_DEF-1:0] pd;
    logic [PREG_W_DEF-1:0] old_pd;
    logic [4:0]            rd;
    logic [6:0]            pc;
    logic [DATA_W_DEF-1:0] result;
  } rob_row_t;

  typedef struct packed {
    logic                  flag;
    logic                  store;
    logic [PREG_W_DEF-1:0] fp;
    logic [4:0]            idx;
    logic [DATA_W_DEF-1:0] result;
    logic [6:0]            pc;
  } ret_slot_t;

  function automatic logic is_store(
    input logic [1:0] t
  );
    return t == ROB_T_STORE;
  endfunction

  function automatic logic writes_reg(
    input logic [1:0] t
  );
    return (t == ROB_T_REG) ||
           (t == ROB_T_LOAD);
  endfunction

endpackage

// File: rtl/rob_retire.sv
// In-order reorder buffer: dual allocate, triple complete,
// dual in-order retire with registered retire pulses.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int IDX_W     = $clog2(ROB_DEPTH),
  parameter int PREG_W    = PREG_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic [1:0]        alloc_type_1,
  input  logic [1:0]        alloc_type_2,
  input  logic [PREG_W-1:0] alloc_pd_1,
  input  logic [PREG_W-1:0] alloc_pd_2,
  input  logic [PREG_W-1:0] alloc_old_pd_1,
  input  logic [PREG_W-1:0] alloc_old_pd_2,
  input  logic [4:0]        alloc_rd_1,
  input  logic [4:0]        alloc_rd_2,
  input  logic [6:0]        alloc_pc_1,
  input  logic [6:0]        alloc_pc_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  input  logic              cmp_valid_1,
  input  logic              cmp_valid_2,
  input  logic              cmp_valid_3,
  input  logic [IDX_W-1:0]  cmp_rob_1,
  input  logic [IDX_W-1:0]  cmp_rob_2,
  input  logic [IDX_W-1:0]  cmp_rob_3,
  input  logic [DATA_W-1:0] cmp_result_1,
  input  logic [DATA_W-1:0] cmp_result_2,
  input  logic [DATA_W-1:0] cmp_result_3,
  output logic              retire_flag_1,
  output logic              retire_flag_2,
  output logic [PREG_W-1:0] fp_ind_1,
  output logic [PREG_W-1:0] fp_ind_2,
  output logic [4:0]        retire_index_1,
  output logic [4:0]        retire_index_2,
  output logic [DATA_W-1:0] retire_result_1,
  output logic [DATA_W-1:0] retire_result_2,
  output logic              retire_store_1,
  output logic              retire_store_2,
  output logic [6:0]        retire_pc_1,
  output logic [6:0]        retire_pc_2,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_empty
);

  localparam logic [IDX_W:0] LIM =
    (IDX_W+1)'(ROB_DEPTH - 2);

  rob_row_t rob_q [ROB_DEPTH];
  rob_row_t rob_d [ROB_DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  ret_slot_t        ret1_q, ret1_d;
  ret_slot_t        ret2_q, ret2_d;

  logic             cv   [3];
  logic [IDX_W-1:0] cr   [3];
  logic [DATA_W-1:0] cres [3];

  logic [IDX_W-1:0] head_p1;
  logic [IDX_W-1:0] tail_p1;
  logic             ret_1, ret_2;
  logic             acc_1, acc_2;
  logic [IDX_W:0]   n_alloc, n_ret;

  assign cv[0]   = cmp_valid_1;
  assign cv[1]   = cmp_valid_2;
  assign cv[2]   = cmp_valid_3;
  assign cr[0]   = cmp_rob_1;
  assign cr[1]   = cmp_rob_2;
  assign cr[2]   = cmp_rob_3;
  assign cres[0] = cmp_result_1;
  assign cres[1] = cmp_result_2;
  assign cres[2] = cmp_result_3;

  function automatic ret_slot_t mk_ret(
    input rob_row_t r
  );
    ret_slot_t s;
    s        = '0;
    s.pc     = r.pc;
    s.result = r.result;
    s.store  = is_store(r.typ);
    s.flag   = writes_reg(r.typ);
    if (s.flag) begin
      s.fp  = r.old_pd;
      s.idx = r.rd;
    end
    return s;
  endfunction

  assign head_p1     = head_q + 1'b1;
  assign tail_p1     = tail_q + 1'b1;
  assign alloc_ready = count_q <= LIM;
  assign alloc_idx_1 = tail_q;
  assign alloc_idx_2 = tail_p1;

  always_comb begin
    rob_d   = rob_q;
    ret1_d  = '0;
    ret2_d  = '0;
    ret_1   = rob_q[head_q].v &&
              rob_q[head_q].comp;
    ret_2   = ret_1 &&
              rob_q[head_p1].v &&
              rob_q[head_p1].comp;
    acc_1   = alloc_ready && alloc_valid_1;
    acc_2   = acc_1 && alloc_valid_2;
    n_alloc = (IDX_W+1)'(acc_1) +
              (IDX_W+1)'(acc_2);
    n_ret   = (IDX_W+1)'(ret_1) +
              (IDX_W+1)'(ret_2);

    // later ports overwrite earlier ones on a shared index
    for (int k = 0; k < 3; k++) begin
      if (cv[k] && rob_q[cr[k]].v) begin
        rob_d[cr[k]].comp   = 1'b1;
        rob_d[cr[k]].result = cres[k];
      end
    end

    if (ret_1) begin
      ret1_d        = mk_ret(rob_q[head_q]);
      rob_d[head_q] = '0;
    end
    if (ret_2) begin
      ret2_d         = mk_ret(rob_q[head_p1]);
      rob_d[head_p1] = '0;
    end

    if (acc_1) begin
      rob_d[tail_q]        = '0;
      rob_d[tail_q].v      = 1'b1;
      rob_d[tail_q].typ    = alloc_type_1;
      rob_d[tail_q].pd     = alloc_pd_1;
      rob_d[tail_q].old_pd = alloc_old_pd_1;
      rob_d[tail_q].rd     = alloc_rd_1;
      rob_d[tail_q].pc     = alloc_pc_1;
    end
    if (acc_2) begin
      rob_d[tail_p1]        = '0;
      rob_d[tail_p1].v      = 1'b1;
      rob_d[tail_p1].typ    = alloc_type_2;
      rob_d[tail_p1].pd     = alloc_pd_2;
      rob_d[tail_p1].old_pd = alloc_old_pd_2;
      rob_d[tail_p1].rd     = alloc_rd_2;
      rob_d[tail_p1].pc     = alloc_pc_2;
    end

    head_d  = head_q + IDX_W'(ret_1) +
              IDX_W'(ret_2);
    tail_d  = tail_q + IDX_W'(acc_1) +
              IDX_W'(acc_2);
    count_d = count_q + n_alloc - n_ret;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ret1_q  <= '0;
      ret2_q  <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ret1_q  <= ret1_d;
      ret2_q  <= ret2_d;
    end
  end

  assign retire_flag_1   = ret1_q.flag;
  assign retire_flag_2   = ret2_q.flag;
  assign retire_store_1  = ret1_q.store;
  assign retire_store_2  = ret2_q.store;
  assign fp_ind_1        = ret1_q.fp;
  assign fp_ind_2        = ret2_q.fp;
  assign retire_index_1  = ret1_q.idx;
  assign retire_index_2  = ret2_q.idx;
  assign retire_result_1 = ret1_q.result;
  assign retire_result_2 = ret2_q.result;
  assign retire_pc_1     = ret1_q.pc;
  assign retire_pc_2     = ret2_q.pc;
  assign rob_count       = count_q;
  assign rob_empty       = count_q == '0;

endmodule

// File: tb/tb_rob_retire.sv
// Randomized + directed bench for rob_retire against a
// program-order queue model of the reorder buffer.
module tb_rob_retire;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_v   [2];
  logic [1:0]  a_t   [2];
  logic [5:0]  a_pd  [2];
  logic [5:0]  a_old [2];
  logic [4:0]  a_rd  [2];
  logic [6:0]  a_pc  [2];
  logic        c_v   [3];
  logic [3:0]  c_r   [3];
  logic [31:0] c_res [3];

  logic        alloc_ready;
  logic [3:0]  alloc_idx_1, alloc_idx_2;
  logic        retire_flag_1, retire_flag_2;
  logic [5:0]  fp_ind_1, fp_ind_2;
  logic [4:0]  retire_index_1, retire_index_2;
  logic [31:0] retire_result_1, retire_result_2;
  logic        retire_store_1, retire_store_2;
  logic [6:0]  retire_pc_1, retire_pc_2;
  logic [4:0]  rob_count;
  logic        rob_empty;

  int errors = 0;
  int checks = 0;
  bit running = 1'b1;

  always #5 clk = ~clk;

  rob_retire dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_1(a_v[0]), .alloc_valid_2(a_v[1]),
    .alloc_type_1(a_t[0]), .alloc_type_2(a_t[1]),
    .alloc_pd_1(a_pd[0]), .alloc_pd_2(a_pd[1]),
    .alloc_old_pd_1(a_old[0]),
    .alloc_old_pd_2(a_old[1]),
    .alloc_rd_1(a_rd[0]), .alloc_rd_2(a_rd[1]),
    .alloc_pc_1(a_pc[0]), .alloc_pc_2(a_pc[1]),
    .alloc_ready(alloc_ready),
    .alloc_idx_1(alloc_idx_1),
    .alloc_idx_2(alloc_idx_2),
    .cmp_valid_1(c_v[0]), .cmp_valid_2(c_v[1]),
    .cmp_valid_3(c_v[2]),
    .cmp_rob_1(c_r[0]), .cmp_rob_2(c_r[1]),
    .cmp_rob_3(c_r[2]),
    .cmp_result_1(c_res[0]),
    .cmp_result_2(c_res[1]),
    .cmp_result_3(c_res[2]),
    .retire_flag_1(retire_flag_1),
    .retire_flag_2(retire_flag_2),
    .fp_ind_1(fp_ind_1), .fp_ind_2(fp_ind_2),
    .retire_index_1(retire_index_1),
    .retire_index_2(retire_index_2),
    .retire_result_1(retire_result_1),
    .retire_result_2(retire_result_2),
    .retire_store_1(retire_store_1),
    .retire_store_2(retire_store_2),
    .retire_pc_1(retire_pc_1),
    .retire_pc_2(retire_pc_2),
    .rob_count(rob_count),
    .rob_empty(rob_empty)
  );

  // model: live entries in program order, oldest first
  typedef struct {
    int          idx;
    logic [1:0]  typ;
    logic [5:0]  old_pd;
    logic [4:0]  rd;
    logic [6:0]  pc;
    bit          comp;
    logic [31:0] res;
  } ment_t;

  ment_t       mq[$];
  int          mtail = 0;
  logic        e_flag  [2];
  logic        e_store [2];
  logic [5:0]  e_fp    [2];
  logic [4:0]  e_idx   [2];
  logic [31:0] e_res   [2];
  logic [6:0]  e_pc    [2];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int    nret;
    ment_t e;
    bit    ready;
    for (int s = 0; s < 2; s++) begin
      e_flag[s] = 0; e_store[s] = 0; e_fp[s] = 0;
      e_idx[s] = 0; e_res[s] = 0; e_pc[s] = 0;
    end
    if (!rst_n) begin
      mq.delete();
      mtail = 0;
      return;
    end
    nret = 0;
    if (mq.size() > 0 && mq[0].comp) nret = 1;
    if (nret == 1 && mq.size() > 1 && mq[1].comp)
      nret = 2;
    for (int s = 0; s < nret; s++) begin
      e_store[s] = (mq[s].typ == 2'd1);
      e_flag[s]  = !e_store[s];
      e_fp[s]    = e_store[s] ? 6'd0 : mq[s].old_pd;
      e_idx[s]   = e_store[s] ? 5'd0 : mq[s].rd;
      e_res[s]   = mq[s].res;
      e_pc[s]    = mq[s].pc;
    end
    ready = mq.size() <= 14;
    for (int k = 0; k < 3; k++) begin
      if (c_v[k]) begin
        foreach (mq[j]) begin
          if (mq[j].idx == int'(c_r[k])) begin
            mq[j].comp = 1;
            mq[j].res  = c_res[k];
          end
        end
      end
    end
    repeat (nret) void'(mq.pop_front());
    if (ready && a_v[0]) begin
      for (int s = 0; s < (a_v[1] ? 2 : 1); s++) begin
        e.idx = mtail; e.typ = a_t[s];
        e.old_pd = a_old[s]; e.rd = a_rd[s];
        e.pc = a_pc[s]; e.comp = 0; e.res = 0;
        mq.push_back(e);
        mtail = (mtail + 1) % 16;
      end
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      chk("count", 32'(rob_count), 32'(mq.size()));
      chk("empty", 32'(rob_empty),
          32'(mq.size() == 0));
      chk("ready", 32'(alloc_ready),
          32'(mq.size() <= 14));
      chk("idx1", 32'(alloc_idx_1), 32'(mtail));
      chk("idx2", 32'(alloc_idx_2),
          32'((mtail + 1) % 16));
      chk("flag1", 32'(retire_flag_1), 32'(e_flag[0]));
      chk("flag2", 32'(retire_flag_2), 32'(e_flag[1]));
      chk("st1", 32'(retire_store_1), 32'(e_store[0]));
      chk("st2", 32'(retire_store_2), 32'(e_store[1]));
      chk("fp1", 32'(fp_ind_1), 32'(e_fp[0]));
      chk("fp2", 32'(fp_ind_2), 32'(e_fp[1]));
      chk("rix1", 32'(retire_index_1), 32'(e_idx[0]));
      chk("rix2", 32'(retire_index_2), 32'(e_idx[1]));
      chk("res1", retire_result_1, e_res[0]);
      chk("res2", retire_result_2, e_res[1]);
      chk("pc1", 32'(retire_pc_1), 32'(e_pc[0]));
      chk("pc2", 32'(retire_pc_2), 32'(e_pc[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    for (int s = 0; s < 2; s++) begin
      a_v[s] = 0; a_t[s] = 0; a_pd[s] = 0;
      a_old[s] = 0; a_rd[s] = 0; a_pc[s] = 0;
    end
    for (int k = 0; k < 3; k++) begin
      c_v[k] = 0; c_r[k] = 0; c_res[k] = 0;
    end
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic set_a(input int s, input int t,
                       input int pd, input int old,
                       input int rd, input int pc);
    a_v[s] = 1; a_t[s] = 2'(t); a_pd[s] = 6'(pd);
    a_old[s] = 6'(old); a_rd[s] = 5'(rd);
    a_pc[s] = 7'(pc);
  endtask

  task automatic set_c(input int k, input int idx,
                       input logic [31:0] v);
    c_v[k] = 1; c_r[k] = 4'(idx); c_res[k] = v;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (k < mq.size())
          set_c(k, mq[k].idx, $urandom);
      end
      tick();
      idle();
    end
    tick();
  endtask

  int p0, p1;

  initial begin
    idle();
    // reset held two cycles with an allocation pending
    rst_n = 0;
    a_v[0] = 1;
    tick();
    tick();
    chk("rst_count", 32'(rob_count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_flag1", 32'(retire_flag_1), 0);
    chk("rst_flag2", 32'(retire_flag_2), 0);
    chk("rst_idx1", 32'(alloc_idx_1), 0);
    rst_n = 1;
    idle();

    // out-of-order completion, dual retire
    set_a(0, 0, 33, 5, 5, 10);
    set_a(1, 0, 34, 6, 6, 11);
    tick();
    idle();
    chk("ooo_count", 32'(rob_count), 2);
    set_c(0, 1, 32'h22);
    tick();
    idle();
    chk("ooo_wait1", 32'(retire_flag_1), 0);
    set_c(0, 0, 32'h11);
    tick();
    idle();
    chk("ooo_wait2", 32'(retire_flag_1), 0);
    tick();
    chk("ooo_flag1", 32'(retire_flag_1), 1);
    chk("ooo_flag2", 32'(retire_flag_2), 1);
    chk("ooo_fp1", 32'(fp_ind_1), 5);
    chk("ooo_fp2", 32'(fp_ind_2), 6);
    chk("ooo_res1", retire_result_1, 32'h11);
    chk("ooo_res2", retire_result_2, 32'h22);
    tick();
    chk("ooo_pulse", 32'(retire_flag_1), 0);
    chk("ooo_empty", 32'(rob_empty), 1);

    // fill to 16, overflow attempt, single retire
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_a(0, 0, 2*i, 2*i, 2*i, 2*i);
      set_a(1, 2, 2*i+1, 2*i+1, 2*i+1, 2*i+1);
      tick();
    end
    chk("full_count", 32'(rob_count), 16);
    chk("full_ready", 32'(alloc_ready), 0);
    tick();
    chk("full_keep", 32'(rob_count), 16);
    chk("full_tail", 32'(alloc_idx_1), 0);
    idle();
    set_c(1, 0, 32'h77);
    tick();
    idle();
    tick();
    chk("full_ret", 32'(retire_flag_1), 1);
    chk("full_ret2", 32'(retire_flag_2), 0);
    chk("full_c15", 32'(rob_count), 15);
    chk("full_rdy15", 32'(alloc_ready), 0);
    drain();

    // pointer wrap with streaming alloc/complete
    do_reset();
    p0 = -1;
    p1 = -1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i == 7) begin
        chk("wrap_i1", 32'(alloc_idx_1), 14);
        chk("wrap_i2", 32'(alloc_idx_2), 15);
      end
      if (i == 8) begin
        chk("wrap_j1", 32'(alloc_idx_1), 0);
        chk("wrap_j2", 32'(alloc_idx_2), 1);
      end
      if (p0 >= 0) begin
        set_c(0, p0, 32'h1000 + i);
        set_c(1, p1, 32'h2000 + i);
      end
      p0 = mtail;
      p1 = (mtail + 1) % 16;
      set_a(0, 0, i, i, i, 2*i);
      set_a(1, 0, i, i + 1, i + 2, 2*i+1);
      tick();
    end
    drain();

    // store retire plus stray completion
    do_reset();
    set_a(0, 1, 18, 7, 3, 44);
    tick();
    idle();
    set_c(1, 5, 32'h55);
    tick();
    idle();
    chk("stray_cnt", 32'(rob_count), 1);
    tick();
    chk("stray_noret", 32'(retire_store_1), 0);
    set_c(2, 0, 32'hDEADBEEF);
    tick();
    idle();
    tick();
    chk("st_store", 32'(retire_store_1), 1);
    chk("st_flag", 32'(retire_flag_1), 0);
    chk("st_res", retire_result_1, 32'hDEADBEEF);
    chk("st_fp", 32'(fp_ind_1), 0);

    // same-index completion on ports 1 and 3
    do_reset();
    set_a(0, 0, 1, 1, 1, 1);
    set_a(1, 0, 2, 2, 2, 2);
    tick();
    set_a(0, 0, 3, 3, 3, 3);
    set_a(1, 0, 4, 4, 4, 4);
    tick();
    idle();
    set_c(0, 0, 32'hA);
    set_c(1, 1, 32'hB);
    tick();
    idle();
    set_a(0, 2, 5, 5, 5, 5);
    set_a(1, 0, 6, 6, 6, 6);
    set_c(0, 2, 32'h1);
    set_c(2, 2, 32'h3);
    tick();
    idle();
    chk("sim_count", 32'(rob_count), 4);
    chk("sim_ret2", 32'(retire_flag_2), 1);
    tick();
    chk("sim_res", retire_result_1, 32'h3);
    chk("sim_one", 32'(retire_flag_2), 0);
    chk("sim_c3", 32'(rob_count), 3);
    drain();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle();
      rst_n = ($urandom_range(0, 99) != 0);
      a_v[0] = ($urandom_range(0, 3) != 0);
      a_v[1] = 1'($urandom_range(0, 1));
      for (int s = 0; s < 2; s++) begin
        a_t[s]   = 2'($urandom_range(0, 2));
        a_pd[s]  = 6'($urandom);
        a_old[s] = 6'($urandom);
        a_rd[s]  = 5'($urandom);
        a_pc[s]  = 7'($urandom);
      end
      for (int k = 0; k < 3; k++) begin
        c_v[k] = ($urandom_range(0, 2) != 0);
        if (mq.size() > 0 &&
            $urandom_range(0, 3) != 0)
          c_r[k] = 4'(mq[$urandom_range(0,
                      mq.size() - 1)].idx);
        else
          c_r[k] = 4'($urandom_range(0, 15));
        c_res[k] = $urandom;
      end
      tick();
    end
    rst_n = 1;
    drain();

    running = 0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order reorder buffer and retire stage for the dual-issue out-of-order RISC-V core.
- Dispatch allocates up to 2 entries per cycle. The three functional-unit result buses mark entries complete out of order.
- The block retires up to 2 entries per cycle in program order.
- On retire it drives the retire_flag/fp_ind interface back to rename, returning old physical registers to the free pool, and drives the architectural writeback/store signals.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of 2.
- IDX_W, 4, log2(ROB_DEPTH).
- PREG_W, 6, physical register index width (64 pregs).
- DATA_W, 32, result width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- alloc_valid_1/alloc_valid_2  in  1  allocation request, slot 1 (older) / slot 2.
- alloc_type_1/alloc_type_2  in  2  0=reg write, 1=store, 2=load to reg.
- alloc_pd_1/alloc_pd_2  in  PREG_W  new destination preg (store: memory address low bits).
- alloc_old_pd_1/alloc_old_pd_2  in  PREG_W  preg previously mapped to rd.
- alloc_rd_1/alloc_rd_2  in  5  architectural destination.
- alloc_pc_1/alloc_pc_2  in  7  instruction PC.
- alloc_ready  out  1  combinational; 1 when count <= ROB_DEPTH-2.
- alloc_idx_1/alloc_idx_2  out  IDX_W  combinational; tail and tail+1 (mod depth).
- cmp_valid_1..3  in  1  FU completion valid.
- cmp_rob_1..3  in  IDX_W  ROB index being completed.
- cmp_result_1..3  in  DATA_W  FU result.
- retire_flag_1/retire_flag_2  out  1  registered; register-type entry retired, free fp_ind.
- fp_ind_1/fp_ind_2  out  PREG_W  old preg to return to the free pool.
- retire_index_1/retire_index_2  out  5  architectural rd.
- retire_result_1/retire_result_2  out  DATA_W  committed value.
- retire_store_1/retire_store_2  out  1  registered; store entry retired.
- retire_pc_1/retire_pc_2  out  7  PC of the retired entry.
- rob_count  out  IDX_W+1  occupancy.
- rob_empty  out  1  count==0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - head=tail=0, count=0, all entry v=0 and comp=0.
  - All retire_* outputs, retire_flag_*, fp_ind_* and retire_pc_* are 0.
  - Reset overrides same-cycle alloc and completion. Reset mid-operation discards all in-flight entries.
- Allocation:
  - Accepted only when alloc_ready=1.
  - alloc_valid_2 is honoured only together with alloc_valid_1; valid_2 alone is ignored.
  - Each accepted slot writes v=1, comp=0 at tail / tail+1. tail advances by 0, 1 or 2, wrapping mod ROB_DEPTH.
  - alloc_ready uses the pre-update count; a same-cycle retire does not raise it.
- Completion:
  - For each cmp_valid_k, if entry[cmp_rob_k].v=1, set comp=1 and result=cmp_result_k.
  - Completion to an entry with v=0 is ignored.
  - Two ports naming the same index in one cycle: the highest-numbered port wins.
  - Completion and allocation to the same index in one cycle cannot occur (the index is not live); allocation wins.
- Retire, evaluated on registered state:
  - Slot 1 retires when entry[head].v and comp are both 1.
  - Slot 2 retires only when slot 1 retires and entry[head+1].v and comp are both 1.
  - A completion written at edge N is retirable at edge N+1; there is no bypass. Minimum complete-to-retire latency is 1 cycle, and retire outputs are visible after that edge.
  - Retired entries are cleared (v=0, comp=0). head advances by the number retired, mod depth.
- Retire outputs:
  - Type 0 and type 2: retire_flag=1, fp_ind=old_pd, retire_index=rd, retire_result=result.
  - Type 1: retire_flag=0, retire_store=1, retire_result=store data, fp_ind=0.
  - All retire outputs are single-cycle pulses; zero when not retiring.
- Occupancy:
  - count_next = count + n_alloc - n_retire, always in 0..ROB_DEPTH.
  - Full (16): alloc_ready=0; retire proceeds.
  - Empty: no retire; rob_empty=1.
- Pointer wrap: index 15 -> 0, including for slot 2 allocation and retire.

Decomposition:
- Add to package p:
  - an rd field in rob_row;
  - localparams ROB_T_REG=0, ROB_T_STORE=1, ROB_T_LOAD=2;
  - ROB_DEPTH default.
- The entry array is a rob_row array local to the module.
- No sub-module; a single module of about 250 lines.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with alloc_valid_1=1.
  - Required: rob_count=0, alloc_ready=1, all retire_flag=0, alloc_idx_1=0.
- Out-of-order completion:
  - Stimulus: allocate A (pd 33, old 5, rd 5) and B (pd 34, old 6, rd 6) at idx 0/1. Complete B with 0x22, then A with 0x11 one cycle later.
  - Required: nothing retires until A completes. One cycle after A completes, both retire in one cycle: fp_ind_1=5, fp_ind_2=6, retire_result_1=0x11, retire_result_2=0x22.
- Full:
  - Stimulus: 8 dual allocations with no completions.
  - Required: rob_count=16, alloc_ready=0; a 9th request is not accepted and tail is unchanged.
  - Then complete idx 0.
  - Required: one retire; count=15; alloc_ready stays 0 (15 > 14).
- Wrap:
  - Stimulus: cycle 20 allocate/complete pairs.
  - Required: alloc_idx_1=14, alloc_idx_2=15, then 0/1. Retires stay in order across the wrap with no lost entries.
- Store and stray completion:
  - Stimulus: type 1 entry completes with 0xDEADBEEF; a completion targets an invalid idx.
  - Required: retire_store=1, retire_flag=0, result 0xDEADBEEF. The invalid completion changes no state.
- Simultaneous events:
  - Stimulus: ports 1 and 3 complete the same idx with 0x1 and 0x3, while a 2-wide allocation and a 2-wide retire happen in the same cycle.
  - Required: the entry holds 0x3; count is unchanged.
